// File: rtl/cmd_frame_ctrl_pkg.sv
// Shared definitions for the command frame controller: opcodes, FSM encoding
// and the fixed register-file slots used for ALU operands.
package ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OP_A_ADDR = 0;
    localparam int OP_B_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// TX byte stream towards the UART transmitter. A byte moves in any cycle where
// TX_D_VLD and TX_READY are both high; once raised, TX_D_VLD and TX_P_DATA stay stable until then.
interface cmd_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  TX_READY;

    modport master (output TX_P_DATA, output TX_D_VLD, input TX_READY);
    modport slave  (input TX_P_DATA, input TX_D_VLD, output TX_READY);
endinterface

// File: rtl/cmd_frame_ctrl_tx.sv
// Holds one or two response bytes and presents them on the TX stream, low
// byte first; reports each accepted byte and whether it was the last one.
module cmd_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  single,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] hi,
    cmd_frame_ctrl_if.master      tx,
    output logic                  accept,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic                  vld_q;
    logic                  last_q;

    assign accept       = vld_q & tx.TX_READY;
    assign last         = last_q;
    assign tx.TX_P_DATA = data_q;
    assign tx.TX_D_VLD  = vld_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            hi_q   <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (load) begin
            data_q <= lo;
            hi_q   <= hi;
            last_q <= single;
            vld_q  <= 1'b1;
        end else if (accept) begin
            // The data register keeps the last byte sent after valid drops.
            if (last_q) begin
                vld_q <= 1'b0;
            end else begin
                data_q <= hi_q;
                last_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command responder: decodes received frames, drives register-file and ALU
// strobes, and returns read or ALU results over the TX stream.
module cmd_frame_ctrl
    import ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic                    CMD_ERR,
    output state_t                  state_dbg,
    cmd_frame_ctrl_if.master        tx
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              fun_q, fun_d;
    logic                    gate_q, gate_d;
    logic                    wr_en_d, rd_en_d, alu_en_d, err_d;
    logic                    tx_load, tx_single, tx_accept, tx_last;
    logic [DATA_WIDTH-1:0]   tx_lo, tx_hi;

    cmd_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .CLK    (CLK),
        .RST    (RST),
        .load   (tx_load),
        .single (tx_single),
        .lo     (tx_lo),
        .hi     (tx_hi),
        .tx     (tx),
        .accept (tx_accept),
        .last   (tx_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fun_d     = fun_q;
        gate_d    = gate_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        err_d     = 1'b0;
        tx_load   = 1'b0;
        tx_single = 1'b0;
        tx_lo     = '0;
        tx_hi     = '0;
        case (state_q)
            IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:      state_d = WR_ADDR;
                    CMD_RD:      state_d = RD_ADDR;
                    CMD_ALU_OP:  state_d = OP_A;
                    CMD_ALU_NOP: begin state_d = FUN; gate_d = 1'b1; end
                    default:     err_d = 1'b1;
                endcase
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_d = 1'b1;
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                err_d = RX_D_VLD;
                if (RF_RD_VLD) begin
                    tx_load   = 1'b1;
                    tx_single = 1'b1;
                    tx_lo     = RF_RD_DATA;
                    state_d   = TX_LO;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OP_A: if (RX_D_VLD) begin
                addr_d  = ADDR_WIDTH'(OP_A_ADDR);
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = OP_B;
            end
            OP_B: if (RX_D_VLD) begin
                addr_d  = ADDR_WIDTH'(OP_B_ADDR);
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                gate_d  = 1'b1;
                state_d = FUN;
            end
            FUN: if (RX_D_VLD) begin
                fun_d    = RX_P_DATA[3:0];
                alu_en_d = 1'b1;
                cnt_d    = '0;
                state_d  = ALU_WAIT;
            end
            ALU_WAIT: begin
                err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    tx_load = 1'b1;
                    tx_lo   = ALU_OUT[DATA_WIDTH-1:0];
                    tx_hi   = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    gate_d  = 1'b0;
                    state_d = TX_LO;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_LO: begin
                err_d = RX_D_VLD;
                if (tx_accept) state_d = tx_last ? IDLE : TX_HI;
            end
            TX_HI: begin
                err_d = RX_D_VLD;
                if (tx_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered here so every pulse lands one cycle after its byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fun_q    <= '0;
            gate_q   <= 1'b0;
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            CMD_ERR  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fun_q    <= fun_d;
            gate_q   <= gate_d;
            RF_WR_EN <= wr_en_d;
            RF_RD_EN <= rd_en_d;
            ALU_EN   <= alu_en_d;
            CMD_ERR  <= err_d;
        end
    end

    assign RF_ADDR     = addr_q;
    assign RF_WR_DATA  = wdata_q;
    assign ALU_FUN     = fun_q;
    assign CLK_GATE_EN = gate_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed bench for cmd_frame_ctrl: write, read, ALU with/without operands,
// TX back-pressure, bad opcode, read timeout and mid-frame reset.
module tb_cmd_frame_ctrl;
  import ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, CMD_ERR;
  logic [3:0]  RF_ADDR, ALU_FUN;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  state_t      state_dbg;

  cmd_frame_ctrl_if #(.DATA_WIDTH(8)) tx_if ();

  cmd_frame_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .RF_WR_EN    (RF_WR_EN),
    .RF_RD_EN    (RF_RD_EN),
    .RF_ADDR     (RF_ADDR),
    .RF_WR_DATA  (RF_WR_DATA),
    .RF_RD_DATA  (RF_RD_DATA),
    .RF_RD_VLD   (RF_RD_VLD),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .CLK_GATE_EN (CLK_GATE_EN),
    .CMD_ERR     (CMD_ERR),
    .state_dbg   (state_dbg),
    .tx          (tx_if)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, tx_if.TX_P_DATA, tx_if.TX_D_VLD, CMD_ERR});
  endfunction

  always @(negedge CLK) begin
    if (RF_WR_EN) wr_cnt++;
    if (RF_RD_EN) rd_cnt++;
    if (ALU_EN)   alu_cnt++;
    if (CMD_ERR)  err_cnt++;
    if (tx_if.TX_D_VLD && tx_if.TX_READY) begin
      tx_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL tx_unexpected: observed byte %0h expected no byte", tx_if.TX_P_DATA);
      end
      if (exp_q.size() != 0) check("tx_byte", 32'(tx_if.TX_P_DATA), 32'(exp_q.pop_front()));
    end
    if (hold_prev) begin
      check("tx_hold_vld", 32'(tx_if.TX_D_VLD), 32'd1);
      check("tx_hold_data", 32'(tx_if.TX_P_DATA), 32'(prev_data));
    end
    hold_prev = tx_if.TX_D_VLD && !tx_if.TX_READY;
    prev_data = tx_if.TX_P_DATA;
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  int base_wr, base_rd, base_alu, base_err, base_tx, n_wait;

  initial begin
    tx_if.TX_READY = 1'b1;

    // reset
    repeat (3) tick();
    check("reset_outs", outs(), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    RST = 1'b0;
    tick();

    // write AA 05 AB
    base_wr = wr_cnt; base_tx = tx_cnt;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'hAB);
    check("wr_en", 32'(RF_WR_EN), 32'd1);
    check("wr_addr", 32'(RF_ADDR), 32'h5);
    check("wr_data", 32'(RF_WR_DATA), 32'hAB);
    check("wr_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) tick();
    check("wr_count", 32'(wr_cnt - base_wr), 32'd1);
    check("wr_no_tx", 32'(tx_cnt - base_tx), 32'd0);

    // write with address byte wider than ADDR_WIDTH
    send_byte(8'hAA); send_byte(8'hF7); send_byte(8'h5A);
    check("trunc_addr", 32'(RF_ADDR), 32'h7);
    check("trunc_data", 32'(RF_WR_DATA), 32'h5A);
    check("trunc_no_err", 32'(CMD_ERR), 32'd0);
    tick();

    // read BB 05, RF answers 0xAB
    base_rd = rd_cnt; base_tx = tx_cnt;
    exp_q.push_back(8'hAB);
    send_byte(8'hBB); send_byte(8'h05);
    check("rd_en", 32'(RF_RD_EN), 32'd1);
    check("rd_addr", 32'(RF_ADDR), 32'h5);
    check("rd_state", 32'(state_dbg), 32'(RD_WAIT));
    repeat (2) tick();
    RF_RD_DATA = 8'hAB; RF_RD_VLD = 1'b1;
    tick();
    RF_RD_VLD = 1'b0;
    check("rd_tx_vld", 32'(tx_if.TX_D_VLD), 32'd1);
    check("rd_tx_data", 32'(tx_if.TX_P_DATA), 32'hAB);
    check("rd_tx_state", 32'(state_dbg), 32'(TX_LO));
    tick();
    check("rd_done_vld", 32'(tx_if.TX_D_VLD), 32'd0);
    check("rd_done_state", 32'(state_dbg), 32'(IDLE));
    check("rd_count", 32'(rd_cnt - base_rd), 32'd1);
    check("rd_tx_count", 32'(tx_cnt - base_tx), 32'd1);

    // ALU with operands CC 08 04 00, result 0x000C
    base_wr = wr_cnt; base_alu = alu_cnt; base_tx = tx_cnt;
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
    send_byte(8'hCC);
    send_byte(8'h08);
    check("opa_wr_en", 32'(RF_WR_EN), 32'd1);
    check("opa_addr", 32'(RF_ADDR), 32'h0);
    check("opa_data", 32'(RF_WR_DATA), 32'h08);
    check("opa_gate", 32'(CLK_GATE_EN), 32'd0);
    send_byte(8'h04);
    check("opb_wr_en", 32'(RF_WR_EN), 32'd1);
    check("opb_addr", 32'(RF_ADDR), 32'h1);
    check("opb_data", 32'(RF_WR_DATA), 32'h04);
    check("fun_state", 32'(state_dbg), 32'(FUN));
    check("fun_gate", 32'(CLK_GATE_EN), 32'd1);
    send_byte(8'h00);
    check("alu_en", 32'(ALU_EN), 32'd1);
    check("alu_fun", 32'(ALU_FUN), 32'h0);
    check("alu_wait_gate", 32'(CLK_GATE_EN), 32'd1);
    check("alu_wait_state", 32'(state_dbg), 32'(ALU_WAIT));
    ALU_OUT = 16'h000C; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    check("cap_gate", 32'(CLK_GATE_EN), 32'd0);
    check("cap_tx_vld", 32'(tx_if.TX_D_VLD), 32'd1);
    check("cap_tx_lo", 32'(tx_if.TX_P_DATA), 32'h0C);
    tick();
    check("alu_tx_hi", 32'(tx_if.TX_P_DATA), 32'h00);
    check("alu_hi_state", 32'(state_dbg), 32'(TX_HI));
    tick();
    check("alu_done_state", 32'(state_dbg), 32'(IDLE));
    check("alu_done_vld", 32'(tx_if.TX_D_VLD), 32'd0);
    check("alu_wr_count", 32'(wr_cnt - base_wr), 32'd2);
    check("alu_en_count", 32'(alu_cnt - base_alu), 32'd1);
    check("alu_tx_count", 32'(tx_cnt - base_tx), 32'd2);

    // ALU without operands DD 01, TX back-pressure
    base_tx = tx_cnt;
    tx_if.TX_READY = 1'b0;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'hDD);
    check("nop_gate", 32'(CLK_GATE_EN), 32'd1);
    check("nop_state", 32'(state_dbg), 32'(FUN));
    send_byte(8'h01);
    check("nop_alu_en", 32'(ALU_EN), 32'd1);
    check("nop_alu_fun", 32'(ALU_FUN), 32'h1);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    repeat (10) tick();
    check("bp_lo_data", 32'(tx_if.TX_P_DATA), 32'h34);
    check("bp_lo_state", 32'(state_dbg), 32'(TX_LO));
    check("bp_none_sent", 32'(tx_cnt - base_tx), 32'd0);
    tx_if.TX_READY = 1'b1;
    tick();
    tx_if.TX_READY = 1'b0;
    check("bp_hi_data", 32'(tx_if.TX_P_DATA), 32'h12);
    check("bp_hi_state", 32'(state_dbg), 32'(TX_HI));
    repeat (3) tick();
    check("bp_hi_vld", 32'(tx_if.TX_D_VLD), 32'd1);
    tx_if.TX_READY = 1'b1;
    tick();
    check("bp_done_state", 32'(state_dbg), 32'(IDLE));
    check("bp_tx_count", 32'(tx_cnt - base_tx), 32'd2);

    // bad opcode, then read timeout with a stray byte in RD_WAIT
    base_err = err_cnt; base_tx = tx_cnt;
    send_byte(8'h55);
    check("bad_op_err", 32'(CMD_ERR), 32'd1);
    check("bad_op_state", 32'(state_dbg), 32'(IDLE));
    tick();
    check("bad_op_pulse", 32'(CMD_ERR), 32'd0);
    send_byte(8'hBB); send_byte(8'h03);
    check("to_state", 32'(state_dbg), 32'(RD_WAIT));
    send_byte(8'h77);
    check("stray_err", 32'(CMD_ERR), 32'd1);
    check("stray_state", 32'(state_dbg), 32'(RD_WAIT));
    n_wait = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (state_dbg == IDLE) begin
        n_wait = i;
        break;
      end
    end
    check("to_cycles", 32'(n_wait), 32'd255);
    check("to_err", 32'(CMD_ERR), 32'd1);
    tick();
    check("to_err_count", 32'(err_cnt - base_err), 32'd3);
    check("to_no_tx", 32'(tx_cnt - base_tx), 32'd0);

    // reset mid-frame, then a clean write
    base_wr = wr_cnt;
    send_byte(8'hAA); send_byte(8'h05);
    RST = 1'b1;
    tick();
    check("mid_rst_outs", outs(), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    RST = 1'b0;
    tick();
    send_byte(8'hAA); send_byte(8'h06); send_byte(8'h11);
    check("post_rst_wr_en", 32'(RF_WR_EN), 32'd1);
    check("post_rst_addr", 32'(RF_ADDR), 32'h6);
    check("post_rst_data", 32'(RF_WR_DATA), 32'h11);
    tick();
    check("post_rst_wr_count", 32'(wr_cnt - base_wr), 32'd1);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
- Command responder between the UART RX/TX datapath and the register file / ALU.
- Consumes received bytes and decodes command frames: 0xAA write, 0xBB read, 0xCC ALU op with operands, 0xDD ALU op without operands.
- Drives RF and ALU strobes, then returns result bytes to the UART TX path over a valid/ready handshake.
- All inputs are already synchronized into the CLK domain.

Parameters:
- ADDR_WIDTH, 4, RF address width; the address byte is truncated to this width.
- DATA_WIDTH, 8, frame byte width.
- TIMEOUT, 255, maximum CLK cycles to wait for RF_RD_VLD or ALU_OUT_VLD.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid in that cycle.
- RF_WR_EN  out  1  RF write strobe.
- RF_RD_EN  out  1  RF read strobe.
- RF_ADDR  out  ADDR_WIDTH  RF address.
- RF_WR_DATA  out  8  RF write data.
- RF_RD_DATA  in  8  RF read data.
- RF_RD_VLD  in  1  read data valid.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function code.
- ALU_OUT  in  16  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  8  byte to transmit.
- TX_D_VLD  out  1  TX byte valid.
- TX_READY  in  1  TX accepts the byte in a cycle where TX_D_VLD and TX_READY are both high.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset asserted mid-frame aborts the frame; no partial RF write is issued.
- RF_WR_EN, RF_RD_EN, ALU_EN and CMD_ERR are single-cycle, registered pulses. All other outputs are registered and hold their value between updates.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on RX_D_VLD:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> OP_A.
  - 0xDD -> FUN.
  - any other byte -> CMD_ERR pulse, stay in IDLE.
- Write (0xAA):
  - WR_ADDR latches RF_ADDR = byte[ADDR_WIDTH-1:0], then -> WR_DATA.
  - WR_DATA: on the byte, RF_WR_DATA = byte and RF_WR_EN pulses in the next cycle; -> IDLE.
- Read (0xBB):
  - RD_ADDR latches the address and pulses RF_RD_EN in the next cycle; -> RD_WAIT.
  - RD_WAIT: on RF_RD_VLD, TX_P_DATA = RF_RD_DATA and TX_D_VLD = 1; -> TX_LO with a single-byte flag set.
- ALU op with operands (0xCC):
  - OP_A: on the byte, RF_WR_EN pulses with RF_ADDR = 0; -> OP_B.
  - OP_B: same, with RF_ADDR = 1; -> FUN.
- FUN:
  - CLK_GATE_EN rises on entry to FUN.
  - On the function byte, ALU_FUN = byte[3:0] and ALU_EN pulses in the next cycle; -> ALU_WAIT.
- ALU_WAIT:
  - On ALU_OUT_VLD, capture the 16-bit result; TX_P_DATA = ALU_OUT[7:0], TX_D_VLD = 1; -> TX_LO.
  - CLK_GATE_EN drops in the cycle after capture.
- TX_LO:
  - TX_D_VLD and TX_P_DATA are held stable until TX_READY.
  - On acceptance: single-byte flag set -> IDLE with TX_D_VLD = 0; otherwise load ALU_OUT[15:8] and -> TX_HI.
- TX_HI: on acceptance -> IDLE.
- Timeout:
  - A wait counter is cleared on entry to RD_WAIT or ALU_WAIT and increments each cycle.
  - When it reaches TIMEOUT: CMD_ERR pulse, CLK_GATE_EN = 0, -> IDLE, nothing is transmitted.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: the byte is dropped and CMD_ERR pulses; the state is unchanged.
- RX_D_VLD coincident with RF_RD_VLD or ALU_OUT_VLD: the valid is served and the byte is dropped with CMD_ERR.
- Address bytes wider than ADDR_WIDTH are silently truncated (no error).

Decomposition:
- Shared package (ctrl_pkg): command opcodes (0xAA/0xBB/0xCC/0xDD), the FSM state encoding, and the operand addresses (OP_A_ADDR = 0, OP_B_ADDR = 1).
- One natural sub-module: cmd_tx_serializer, which owns the TX_LO/TX_HI byte holding and the valid/ready handshake for 1 or 2 bytes.
- Decode and the RF/ALU strobes stay in the top FSM.

Test Plan:
- RX bytes AA, 05, AB -> exactly one RF_WR_EN pulse with RF_ADDR = 5, RF_WR_DATA = 0xAB; no TX activity.
- BB, 05; RF returns RF_RD_VLD with 0xAB after 3 cycles -> one RF_RD_EN with RF_ADDR = 5; a single TX byte 0xAB accepted; FSM back in IDLE.
- CC, 08, 04, 00; ALU returns 0x000C -> RF writes 0x08 at address 0 and 0x04 at address 1; ALU_FUN = 0; one ALU_EN pulse; TX bytes 0x0C then 0x00; CLK_GATE_EN high from FUN entry until the cycle after capture.
- DD, 01 with TX_READY held low for 10 cycles -> TX_D_VLD and TX_P_DATA stable throughout; each of the two bytes is accepted exactly once.
- Byte 0x55 in IDLE -> one CMD_ERR pulse. BB, 03 with RF_RD_VLD never asserted -> CMD_ERR at TIMEOUT, FSM back in IDLE, no TX.
- RST asserted after AA, 05 -> all outputs 0. The following AA, 06, 11 yields a clean write of 0x11 at address 6.
